// File: rtl/ssm_pkg.sv
// Shared definitions for the snapshot-store write path: stream header tags,
// capture FSM state encoding and the width helper used for derived parameters.
package ssm_pkg;

    localparam logic [1:0] HDR_HEAD = 2'b01;
    localparam logic [1:0] HDR_MID  = 2'b11;
    localparam logic [1:0] HDR_TAIL = 2'b10;

    typedef enum logic [1:0] {
        IDLE_S  = 2'd0,
        WRITE_S = 2'd1,
        DROP_S  = 2'd2,
        CLEAR_S = 2'd3
    } ssm_state_e;

    function automatic int ssm_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ssm_slot_alloc.sv
// Slot bookkeeping for the snapshot store: write slot pointer, committed-slot
// occupancy, the stop-mode full flag and the refused-head counter.
module ssm_slot_alloc #(
    parameter int SLOT_NUM = 16,
    parameter int SLOT_W   = 4,
    parameter int LEN_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              cfg_wrap,
    input  logic              commit,
    input  logic              drop,
    output logic [SLOT_W-1:0] wr_slot,
    output logic [LEN_W-1:0]  slot_used,
    output logic              full,
    output logic              full_now,
    output logic [15:0]       drop_cnt
);

    localparam logic [LEN_W-1:0] USED_MAX = LEN_W'(SLOT_NUM);

    logic [SLOT_W-1:0] r_wr_slot;
    logic [LEN_W-1:0]  r_slot_used;
    logic              r_full;
    logic [15:0]       r_drop_cnt;
    logic [LEN_W-1:0]  w_used_n;

    assign w_used_n = (commit && (r_slot_used != USED_MAX)) ? r_slot_used + LEN_W'(1) : r_slot_used;
    // Head admission looks at the live mode so a cfg_wrap change applies to the very next head.
    assign full_now = !cfg_wrap && (r_slot_used == USED_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_slot   <= '0;
            r_slot_used <= '0;
            r_full      <= 1'b0;
            r_drop_cnt  <= '0;
        end else if (clear) begin
            r_wr_slot   <= '0;
            r_slot_used <= '0;
            r_full      <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            if (commit) begin
                r_wr_slot <= r_wr_slot + SLOT_W'(1);
            end
            r_slot_used <= w_used_n;
            r_full      <= !cfg_wrap && (w_used_n == USED_MAX);
            if (drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign wr_slot   = r_wr_slot;
    assign slot_used = r_slot_used;
    assign full      = r_full;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: rtl/ssm_wr_ring.sv
// Snapshot-store write side: captures stream packets into per-slot RAM regions,
// stamps one word with the local time and reports each completed slot.
module ssm_wr_ring
    import ssm_pkg::*;
#(
    parameter int DATA_W     = 134,
    parameter int TS_W       = 64,
    parameter int TS_WORD    = 5,
    parameter int SLOT_NUM   = 16,
    parameter int SLOT_DEPTH = 128,
    parameter int SLOT_W     = ssm_clog2(SLOT_NUM),
    parameter int LEN_W      = ssm_clog2(SLOT_DEPTH) + 1,
    parameter int ADDR_W     = SLOT_W + ssm_clog2(SLOT_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              cfg_wrap,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_data_wr,
    input  logic [TS_W-1:0]   lcm_time,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wr,
    output logic              commit_valid,
    output logic [SLOT_W-1:0] commit_slot,
    output logic [LEN_W-1:0]  commit_len,
    output logic              commit_trunc,
    output logic [LEN_W-1:0]  slot_used,
    output logic              full,
    output logic [15:0]       drop_cnt,
    output logic [15:0]       err_cnt
);

    localparam int               DEPTH_W   = ADDR_W - SLOT_W;
    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(SLOT_DEPTH);
    localparam logic [LEN_W-1:0] TS_IDX    = LEN_W'(TS_WORD);

    ssm_state_e        r_state, w_state_n;
    logic [LEN_W-1:0]  r_cnt, w_cnt_n;
    logic              r_trunc, w_trunc_n;
    logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_n;
    logic [DATA_W-1:0] r_ram_wdata, w_ram_wdata_n;
    logic              r_ram_wr;
    logic              r_commit_valid;
    logic [SLOT_W-1:0] r_commit_slot;
    logic [LEN_W-1:0]  r_commit_len;
    logic              r_commit_trunc;
    logic [15:0]       r_err_cnt;
    logic              w_err;
    logic              w_drop;
    logic              w_commit;
    logic              w_do_wr;
    logic [LEN_W-1:0]  w_idx;
    logic [1:0]        w_hdr;
    logic [SLOT_W-1:0] w_wr_slot;
    logic              w_full_now;

    function automatic logic [DATA_W-1:0] stamp_word(input logic [DATA_W-1:0] word,
                                                     input logic [TS_W-1:0]   ts);
        return {word[DATA_W-1:TS_W], ts};
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    ssm_slot_alloc #(
        .SLOT_NUM (SLOT_NUM),
        .SLOT_W   (SLOT_W),
        .LEN_W    (LEN_W)
    ) u_slot_alloc (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .cfg_wrap  (cfg_wrap),
        .commit    (w_commit),
        .drop      (w_drop),
        .wr_slot   (w_wr_slot),
        .slot_used (slot_used),
        .full      (full),
        .full_now  (w_full_now),
        .drop_cnt  (drop_cnt)
    );

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_trunc_n = r_trunc;
        w_err     = 1'b0;
        w_drop    = 1'b0;
        w_commit  = 1'b0;
        w_do_wr   = 1'b0;
        w_idx     = r_cnt;
        w_hdr     = in_data[DATA_W-1 -: 2];
        case (r_state)
            IDLE_S: begin
                if (in_data_wr) begin
                    if (w_hdr == HDR_HEAD) begin
                        if (w_full_now) begin
                            w_drop    = 1'b1;
                            w_state_n = DROP_S;
                        end else begin
                            w_do_wr   = 1'b1;
                            w_idx     = '0;
                            w_cnt_n   = LEN_W'(1);
                            w_trunc_n = 1'b0;
                            w_state_n = WRITE_S;
                        end
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            WRITE_S: begin
                if (in_data_wr) begin
                    if (w_hdr == HDR_HEAD) begin
                        // Unterminated packet: drop it and reuse the same slot base.
                        w_err     = 1'b1;
                        w_do_wr   = 1'b1;
                        w_idx     = '0;
                        w_cnt_n   = LEN_W'(1);
                        w_trunc_n = 1'b0;
                    end else if ((w_hdr == HDR_MID) || (w_hdr == HDR_TAIL)) begin
                        if (r_cnt < DEPTH_LEN) begin
                            w_do_wr = 1'b1;
                            w_cnt_n = r_cnt + LEN_W'(1);
                        end else begin
                            w_trunc_n = 1'b1;
                        end
                        if (w_hdr == HDR_TAIL) begin
                            w_commit  = 1'b1;
                            w_state_n = IDLE_S;
                        end
                    end else begin
                        w_err     = 1'b1;
                        w_state_n = IDLE_S;
                    end
                end
            end
            DROP_S: begin
                if (in_data_wr) begin
                    if (w_hdr == HDR_HEAD) begin
                        w_drop = 1'b1;
                    end else if (w_hdr == HDR_TAIL) begin
                        w_state_n = IDLE_S;
                    end
                end
            end
            default: begin
                w_state_n = IDLE_S;
            end
        endcase
        w_ram_addr_n  = w_do_wr ? {w_wr_slot, w_idx[DEPTH_W-1:0]} : r_ram_addr;
        w_ram_wdata_n = !w_do_wr ? r_ram_wdata :
                        (w_idx == TS_IDX) ? stamp_word(in_data, lcm_time) : in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE_S;
            r_cnt          <= '0;
            r_trunc        <= 1'b0;
            r_ram_addr     <= '0;
            r_ram_wdata    <= '0;
            r_ram_wr       <= 1'b0;
            r_commit_valid <= 1'b0;
            r_commit_slot  <= '0;
            r_commit_len   <= '0;
            r_commit_trunc <= 1'b0;
            r_err_cnt      <= '0;
        end else if (clear) begin
            r_state        <= CLEAR_S;
            r_cnt          <= '0;
            r_trunc        <= 1'b0;
            r_ram_addr     <= '0;
            r_ram_wdata    <= '0;
            r_ram_wr       <= 1'b0;
            r_commit_valid <= 1'b0;
            r_commit_slot  <= '0;
            r_commit_len   <= '0;
            r_commit_trunc <= 1'b0;
            r_err_cnt      <= '0;
        end else begin
            r_state        <= w_state_n;
            r_cnt          <= w_cnt_n;
            r_trunc        <= w_trunc_n;
            r_ram_addr     <= w_ram_addr_n;
            r_ram_wdata    <= w_ram_wdata_n;
            r_ram_wr       <= w_do_wr;
            r_commit_valid <= w_commit;
            if (w_commit) begin
                r_commit_slot  <= w_wr_slot;
                r_commit_len   <= w_cnt_n;
                r_commit_trunc <= w_trunc_n;
            end
            if (w_err) begin
                r_err_cnt <= sat_inc16(r_err_cnt);
            end
        end
    end

    assign ram_addr     = r_ram_addr;
    assign ram_wdata    = r_ram_wdata;
    assign ram_wr       = r_ram_wr;
    assign commit_valid = r_commit_valid;
    assign commit_slot  = r_commit_slot;
    assign commit_len   = r_commit_len;
    assign commit_trunc = r_commit_trunc;
    assign err_cnt      = r_err_cnt;

endmodule

// File: doc/ssm_wr_ring.md
Name: ssm_wr_ring

Overview:
Parametrised successor of the snapshot-store write side. Captures whole packets from the 134-bit pipeline stream into a slotted snapshot RAM, one packet per slot. Replaces the low bits of a configurable word with the local clock-module timestamp. Adds ring/stop modes, slot-overflow truncation, error abort and commit reporting to the read-side FSM. Sits between the pipeline tap and the snapshot RAM write port; ssm_rd consumes the commit stream.

Parameters:
DATA_W, 134, stream word width; bits [DATA_W-1:DATA_W-2] are the header tag (01 head, 11 middle, 10 tail)
TS_W, 64, timestamp width; stamped into bits [TS_W-1:0]
TS_WORD, 5, zero-based word index (head = 0) that receives the timestamp
SLOT_NUM, 16, number of packet slots (power of 2)
SLOT_DEPTH, 128, words per slot (power of 2)
SLOT_W, log2(SLOT_NUM), slot index width (derived)
LEN_W, log2(SLOT_DEPTH)+1, length width (derived)
ADDR_W, SLOT_W+log2(SLOT_DEPTH), RAM address width (derived)

Ports:
clk  in  1  single clock
rst  in  1  reset; asynchronous, active-high
clear  in  1  synchronous soft clear from the control path
cfg_wrap  in  1  1 = ring mode (overwrite oldest slot), 0 = stop when full
in_data  in  DATA_W  stream word
in_data_wr  in  1  in_data valid
lcm_time  in  TS_W  local timestamp
ram_addr  out  ADDR_W  RAM write address
ram_wdata  out  DATA_W  RAM write data
ram_wr  out  1  RAM write enable
commit_valid  out  1  one-cycle pulse: slot completed
commit_slot  out  SLOT_W  committed slot index
commit_len  out  LEN_W  words stored in the committed slot
commit_trunc  out  1  committed packet exceeded SLOT_DEPTH
slot_used  out  LEN_W  committed slots since clear, saturating at SLOT_NUM
full  out  1  stop mode and slot_used == SLOT_NUM
drop_cnt  out  16  heads refused while full, saturating
err_cnt  out  16  aborted packets plus stray words, saturating

Behaviour:
- rst (async) or clear (sync, highest priority over every other event) zeroes all outputs, the write slot pointer, the word counter and the state; state -> CLEAR_S while clear = 1, else IDLE_S.
- All outputs are registered. A RAM write appears one cycle after the accepted input word.
- States:
  - IDLE_S: on an in_data_wr head:
    - full = 1: drop the packet, drop_cnt++, -> DROP_S.
    - Otherwise: write the head to {wr_slot, 0}, word count = 1, -> WRITE_S.
    - A non-head word with in_data_wr: ignore it, err_cnt++.
  - WRITE_S:
    - in_data_wr = 0: hold state and pointers, ram_wr = 0. The packet is not aborted.
    - Middle or tail word with word count < SLOT_DEPTH: write to {wr_slot, count}; count++.
    - Middle or tail word with word count = SLOT_DEPTH: no RAM write; set trunc.
    - Word index == TS_WORD: ram_wdata = {in_data[DATA_W-1:TS_W], lcm_time}.
    - Tail: commit_valid = 1 in the same cycle as the tail ram_wr (or the tail cycle if truncated). commit_slot = wr_slot, commit_len = words stored, commit_trunc = trunc. Then wr_slot++ (wraps SLOT_NUM-1 -> 0), slot_used++ (saturating), -> IDLE_S.
    - Head in WRITE_S: abort, err_cnt++, no commit. Restart the new packet at {wr_slot, 0}, stay in WRITE_S.
    - Header 00 with in_data_wr: abort, err_cnt++, -> IDLE_S. The slot is reused.
  - DROP_S: discard words until a tail, then -> IDLE_S. A head here restarts the drop; drop_cnt++ again.
  - CLEAR_S: outputs held at zero until clear = 0, then -> IDLE_S.
- full = !cfg_wrap && slot_used == SLOT_NUM. In ring mode full never asserts; the oldest slot is overwritten and ssm_rd tracks it via commit_slot.
- Changing cfg_wrap takes effect at the next head only.
- Packets shorter than TS_WORD+1 words carry no timestamp.
- Counters saturate at all-ones.

Decomposition:
- Shared package ssm_pkg: header tag constants (HDR_HEAD = 2'b01, HDR_MID = 2'b11, HDR_TAIL = 2'b10), state encodings, and the clog2 helper used by the derived parameters.
- One natural sub-module: ssm_slot_alloc. It holds wr_slot, slot_used, full and drop_cnt, with commit and clear inputs. The capture FSM stays in ssm_wr_ring.

Test Plan:
- 8-word packet, lcm_time = 64'h1234: slot 0 words 0-7 written. Word 5 low 64 bits = 64'h1234, others unchanged. commit slot 0, len 8, trunc 0.
- 3-word packet: no stamp, commit len 3. A 1-word gap (in_data_wr = 0) mid-packet is tolerated, with no abort.
- 200-word packet, SLOT_DEPTH = 128: 128 writes, last address {0, 127}. commit len 128, trunc 1.
- cfg_wrap = 0, 17 packets: slots 0-15 committed, full = 1. 17th packet not written, drop_cnt = 1. After clear: slot_used = 0, next packet goes to slot 0.
- cfg_wrap = 1, 17 packets: 17th commits to slot 0, slot_used = 16, full = 0.
- Head after 3 words of a packet: err_cnt = 1, new packet restarts at the same slot base address. Assert clear mid-packet, then rst mid-packet: all outputs return to 0 immediately, with no commit.
